// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request
// at a time and fills the IF/ID register. A one-entry hold buffer absorbs a
// response that arrives while decode is stalled. Redirects from execute
// discard any in-flight wrong-path fetch.
module if_stage #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [WIDTH-1:0] NOP      = 32'h0000_0013
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_imem_req,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic             i_imem_gnt,
    input  logic             i_imem_rvalid,
    input  logic [WIDTH-1:0] i_imem_rdata,
    input  logic             i_stall,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_pc,
    output logic [WIDTH-1:0] o_instruccion,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_valid
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
    localparam logic [WIDTH-1:0] PC_STEP    = {{(WIDTH-3){1'b0}}, 3'b100};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_req_q, pc_req_d;
    logic             kill_q, kill_d;
    logic [WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] opc_q, opc_d;
    logic             valid_q, valid_d;

    logic             ifid_load;
    logic [WIDTH-1:0] ifid_instr;
    logic [WIDTH-1:0] ifid_pc;

    // Request is a pure decode of the state so it is high straight out of reset.
    assign o_imem_req    = (state_q == S_REQ);
    assign o_imem_addr   = pc_q;
    assign o_instruccion = instr_q;
    assign o_pc          = opc_q;
    assign o_valid       = valid_q;

    // Next-state logic: a redirect wins over everything, otherwise run the fetch handshake.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_req_d     = pc_req_q;
        kill_d       = kill_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        instr_d      = instr_q;
        opc_d        = opc_q;
        valid_d      = valid_q;
        ifid_load    = 1'b0;
        ifid_instr   = i_imem_rdata;
        ifid_pc      = pc_req_q;

        if (i_redirect) begin
            // A redirect flushes IF/ID and the hold buffer even under stall;
            // an in-flight fetch is marked for dropping instead of being waited on here.
            pc_d         = i_redirect_pc & ALIGN_MASK;
            valid_d      = 1'b0;
            instr_d      = NOP;
            hold_instr_d = '0;
            hold_pc_d    = '0;
            case (state_q)
                S_REQ: begin
                    if (i_imem_gnt) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (i_imem_gnt) begin
                        pc_req_d = pc_q;
                        pc_d     = pc_q + PC_STEP;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (!valid_q || !i_stall) begin
                            ifid_load = 1'b1;
                            state_d   = S_REQ;
                        end else begin
                            hold_instr_d = i_imem_rdata;
                            hold_pc_d    = pc_req_q;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!i_stall) begin
                        ifid_load  = 1'b1;
                        ifid_instr = hold_instr_q;
                        ifid_pc    = hold_pc_q;
                        state_d    = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase

            // IF/ID either takes the new word, drains to a bubble, or holds under stall.
            if (ifid_load) begin
                instr_d = ifid_instr;
                opc_d   = ifid_pc;
                valid_d = 1'b1;
            end else if (!i_stall) begin
                instr_d = NOP;
                valid_d = 1'b0;
            end
        end
    end

    // State registers, all returned to their reset values asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            pc_req_q     <= '0;
            kill_q       <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            instr_q      <= NOP;
            opc_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_req_q     <= pc_req_d;
            kill_q       <= kill_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_q      <= instr_d;
            opc_q        <= opc_d;
            valid_q      <= valid_d;
        end
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RISC-V pipeline: the producer end of the instruction interface consumed by decode. Holds the PC, issues one word request at a time to instruction memory over a request/grant/response handshake, and loads the returned word into the IF/ID pipeline register (`o_instruccion`, `o_pc`, `o_valid`). Honours decode stalls through a one-entry hold buffer and branch redirects from execute, discarding in-flight wrong-path fetches.

## Interface
- `WIDTH`, 32: data/address width.
- `RESET_PC`, 32'h0000_0000: PC after reset.
- `NOP`, 32'h0000_0013: bubble value (`addi x0,x0,0`).

- `i_clk`  in  1  clock, all state on rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `o_imem_req`  out  1  fetch request valid.
- `o_imem_addr`  out  WIDTH  fetch word address; bits [1:0] always 0.
- `i_imem_gnt`  in  1  request accepted this cycle (meaningful only with `o_imem_req`).
- `i_imem_rvalid`  in  1  response data valid.
- `i_imem_rdata`  in  WIDTH  instruction word.
- `i_stall`  in  1  decode cannot accept; IF/ID register holds.
- `i_redirect`  in  1  taken branch/jump from execute.
- `i_redirect_pc`  in  WIDTH  redirect target; bits [1:0] ignored (forced 0).
- `o_instruccion`  out  WIDTH  IF/ID instruction.
- `o_pc`  out  WIDTH  PC of `o_instruccion`.
- `o_valid`  out  1  IF/ID holds a real instruction.

## Operation
- State: `pc`, `pc_req` (address of the outstanding request), `kill` flag, hold buffer (`hold_instr`, `hold_pc`), FSM {S_REQ, S_WAIT, S_HOLD}. Max one outstanding request.
- S_REQ: `o_imem_req`=1, `o_imem_addr`=`pc`. On `i_imem_gnt`: `pc_req`<=`pc`, `pc`<=`pc`+4 (mod 2^WIDTH), go S_WAIT. Requests issue regardless of `i_stall`.
- S_WAIT: `o_imem_req`=0. On `i_imem_rvalid`:
  - `kill`=1: drop data, clear `kill`, go S_REQ.
  - IF/ID free (`o_valid`=0 or `i_stall`=0): load `o_instruccion`<=`i_imem_rdata`, `o_pc`<=`pc_req`, `o_valid`<=1; go S_REQ.
  - else: capture into hold buffer, go S_HOLD.
- S_HOLD: `o_imem_req`=0. When `i_stall`=0: IF/ID loads the hold buffer, `o_valid`<=1, go S_REQ.
- IF/ID with no new load and `i_stall`=0: `o_valid`<=0, `o_instruccion`<=`NOP`. With `i_stall`=1: hold all three outputs.
- Redirect, highest priority, overrides `i_stall`. In the `i_redirect` cycle:
  - `pc`<=`{i_redirect_pc[WIDTH-1:2],2'b00}`.
  - IF/ID <= `o_valid`=0 / `NOP`, hold buffer discarded.
  - S_REQ without gnt: stay in S_REQ; the new address is presented next cycle.
  - S_REQ with gnt: go S_WAIT with `kill`=1.
  - S_WAIT without rvalid: `kill`<=1.
  - S_WAIT with rvalid: drop data, go S_REQ.
  - S_HOLD: go S_REQ.
- A second redirect while `kill`=1 only updates `pc`.
- `i_imem_rvalid` outside S_WAIT is ignored. A `pc` increment from `32'hFFFF_FFFC` wraps to 0.

## Timing
- Reset values: `pc`=`RESET_PC`, state S_REQ, `kill`=0, `o_valid`=0, `o_instruccion`=`NOP`, `o_pc`=0. Hold buffer is cleared.
- `o_imem_req` is high in the first cycle after reset release.
- Reset asserted mid-fetch returns all state to reset values immediately. A later `i_imem_rvalid` for the aborted fetch is ignored because the FSM is in S_REQ.
- Response `i_imem_rvalid` is at least 1 cycle after gnt; gnt and rvalid in the same cycle is illegal.
- `o_valid` rises on the edge that samples `i_imem_rvalid`, so the instruction is visible in the following cycle.
- Zero-wait memory (gnt in S_REQ, rvalid the next cycle): 1 instruction per 2 cycles.
- Redirect to first correct-path request: `o_imem_req` with the target is visible the cycle after `i_redirect`. Exception: a killed response in flight delays it until 1 cycle after that rvalid.

## Test plan
- Reset, always gnt, rvalid 1 cycle later, rdata = address ^ 32'hA5A5_0000 -> `o_pc` sequence 0,4,8,C; each `o_valid` pulse carries the matching word; requests every 2 cycles.
- `i_stall` held 5 cycles while `o_valid`=1 and a response arrives -> outputs frozen, FSM in S_HOLD, `o_imem_req`=0. On stall release the held word (pc 8) appears next cycle, then fetch of pc C resumes.
- `i_redirect`=1, target 32'h0000_0103, in S_WAIT before rvalid -> late response dropped; next request address 32'h0000_0100; `o_valid`=0 throughout.
- `i_redirect` in the same cycle as gnt for pc 10 -> pc 10 data never reaches `o_valid`; the next request is the target.
- `i_redirect` together with `i_stall` and a held instruction -> `o_valid`=0, `o_instruccion`=32'h0000_0013, hold buffer discarded.
- `RESET_PC`=32'hFFFF_FFFC -> second request address 0. Asserting `i_rst_n`=0 during S_WAIT -> outputs at reset values immediately; a later rvalid is ignored.
